ram_arbiter: RTL
================

# ram_arbiter

Round-robin arbiter that shares the single RAM port among `NREQ` cache-side requesters (instruction and data ports of every core). It grants one requester at a time, forwards its address, data and read/write enables to RAM, and releases the requester's wait on the RAM `ACCESS` cycle. A transfer timeout protects against a stuck RAM. It sits between the cache controllers and the RAM model, replacing fixed-priority single-core muxing.

## Interface
- `NREQ`, 4: number of requesters (index 0..NREQ-1); must be ≥2.
- `TIMEOUT`, 255: maximum cycles spent in `XFER` before the transfer is aborted; must be ≥1.
- `CLK`  in  1  clock, rising edge.
- `RST`  in  1  reset; one clock; reset is asynchronous and active-high.
- `req_ren`  in  NREQ  per-requester read request.
- `req_wen`  in  NREQ  per-requester write request.
- `req_addr`  in  NREQ×32  per-requester word address.
- `req_store`  in  NREQ×32  per-requester write data.
- `req_wait`  out  NREQ  1 = stall; 0 only for the completing requester.
- `req_load`  out  32  `ramload` broadcast to all requesters.
- `ramaddr`  out  32  granted requester's address.
- `ramstore`  out  32  granted requester's write data.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramstate`  in  2  RAM status, `ramstate_t`: FREE, BUSY, ACCESS, ERROR.
- `ramload`  in  32  RAM read data.
- `grant`  out  log2(NREQ)  index of the current or last grant.
- `timeout_err`  out  1  one-cycle pulse on abort.

## Operation
- States: `IDLE`, `XFER`.
- `IDLE`:
  - `ramREN = ramWEN = 0`; all `req_wait = 1`.
  - If any requester is active (`req_ren|req_wen`), select the first active index searching `ptr+1, ptr+2, …` with wrap-around mod NREQ.
  - Register the selection into `grant`, clear the timeout counter, and go to `XFER`.
- `XFER`:
  - Mux `req_addr[grant]` and `req_store[grant]` onto RAM combinationally.
  - `ramWEN = req_wen[grant]`.
  - `ramREN = req_ren[grant] & ~req_wen[grant]`, so write wins when both are set.
  - `ramstate == ACCESS`: `req_wait[grant] = 0` this cycle, `ptr <= grant`, next state `IDLE`.
  - `ramstate` is BUSY, FREE or ERROR: waits stay 1, the counter increments, and the state is held. ERROR is treated as retry-in-place.
  - Granted requester drops both enables: abort to `IDLE` the next edge; `ptr` is unchanged and no wait is released.
  - Counter reaches `TIMEOUT - 1` without `ACCESS`: pulse `timeout_err`, go to `IDLE`, set `ptr <= grant` so the faulty requester loses priority. The requester's wait stays high and it re-arbitrates.
- Non-granted requesters always see `req_wait = 1`. Their request signals are ignored until arbitration.
- `req_load = ramload` at all times.

## Timing
- Reset values:
  - state `IDLE`
  - `ptr = NREQ-1`, so requester 0 wins first
  - `grant = 0`, counter 0
  - `ramREN = ramWEN = 0`, all `req_wait = 1`, `timeout_err = 0`
- Reset mid-`XFER`: RAM enables drop immediately (asynchronous), and the in-flight transfer is lost.
- Latency: request seen in `IDLE` at cycle 0; RAM driven from cycle 1; wait low in the first `XFER` cycle where `ramstate == ACCESS`.
- With a zero-wait RAM, one word completes every 2 cycles. There is always one `IDLE` bubble between grants.
- ACCESS on the same cycle as a requester drop: ACCESS wins and the transfer completes.
- ACCESS on the same cycle as timeout expiry: ACCESS wins, with no `timeout_err`.
- Fairness: with all NREQ requesting continuously, each is served exactly once per NREQ grants.

## Structure
- `ramstate_t` (FREE/BUSY/ACCESS/ERROR) comes from `cpu_types_pkg`.
- Add `arb_state_t` {IDLE, XFER} and the `ARB_TIMEOUT` default to `cpu_types_pkg`.
- Sub-module `rr_picker`: combinational. Inputs are the `NREQ` request vector and `ptr`; outputs are `valid` and `index`, found by search with wrap-around. Instantiated once.

## Test plan
- Reset, no requests: after reset, `ramREN = ramWEN = 0`, all waits 1, `grant = 0`, and these hold for 10 cycles.
- Single read:
  - Stimulus: `req_ren[2] = 1`, `addr = 0x40`; RAM BUSY 2 cycles then ACCESS with `ramload = 0xDEADBEEF`.
  - Response: `ramaddr = 0x40`, `ramREN = 1` from cycle 1; `req_wait[2] = 0` on cycle 3 with `req_load = 0xDEADBEEF`.
- Contention: requesters 0, 1 and 3 request continuously with a zero-wait RAM → grant order 0, 1, 3, 0, 1, 3, with completions every 2 cycles.
- Write priority:
  - Stimulus: `req_ren[1] = req_wen[1] = 1`, `store = 0x1234`; ERROR for 1 cycle then ACCESS.
  - Response: `ramWEN = 1`, `ramREN = 0`, `ramstore = 0x1234`; ERROR retried; wait released on ACCESS.
- Timeout: `TIMEOUT = 4`, RAM stuck BUSY, requesters 0 and 1 request.
  - `timeout_err` pulses in the 4th `XFER` cycle.
  - The next grant is 1; `req_wait[0]` never drops.
- Drop and reset:
  - Requester 2 deasserts mid-`XFER` → `IDLE` next cycle, `ptr` unchanged.
  - `RST` asserted mid-`XFER` → `ramREN` low in the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM status codes plus the RAM arbiter state set and defaults.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      FREE   = 2'b00,
      BUSY   = 2'b01,
      ACCESS = 2'b10,
      ERROR  = 2'b11
   } ramstate_t;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_t;

   localparam int ARB_TIMEOUT = 255;
   localparam int ARB_NREQ    = 4;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request after ptr_i, wrapping mod NREQ.
module rr_picker #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic            valid_o,
   output logic [IW-1:0]   index_o
);

   int            pos;
   logic [IW-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest hit is the one left standing.
   always_comb begin
      valid_o = 1'b0;
      index_o = '0;
      pos     = 0;
      cand    = '0;
      for (int k = NREQ; k >= 1; k--) begin
         pos  = (int'(ptr_i) + k) % NREQ;
         cand = IW'(pos);
         if (req_i[cand]) begin
            valid_o = 1'b1;
            index_o = cand;
         end
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ cache requesters, with a
// per-transfer timeout that aborts a stuck RAM access.
module ram_arbiter
   import cpu_types_pkg::*;
#(
   parameter int NREQ    = ARB_NREQ,
   parameter int TIMEOUT = ARB_TIMEOUT
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [NREQ-1:0]         req_ren,
   input  logic [NREQ-1:0]         req_wen,
   input  logic [NREQ*32-1:0]      req_addr,
   input  logic [NREQ*32-1:0]      req_store,
   output logic [NREQ-1:0]         req_wait,
   output logic [31:0]             req_load,
   output logic [31:0]             ramaddr,
   output logic [31:0]             ramstore,
   output logic                    ramREN,
   output logic                    ramWEN,
   input  logic [1:0]              ramstate,
   input  logic [31:0]             ramload,
   output logic [$clog2(NREQ)-1:0] grant,
   output logic                    timeout_err
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   arb_state_t    state_q, state_d;
   logic [IW-1:0] grant_q, grant_d;
   logic [IW-1:0] ptr_q,   ptr_d;
   logic [CW-1:0] cnt_q,   cnt_d;

   logic [NREQ-1:0] active;
   logic            pick_valid;
   logic [IW-1:0]   pick_index;
   ramstate_t       rs;
   logic [31:0]     addr_arr  [NREQ];
   logic [31:0]     store_arr [NREQ];

   assign active   = req_ren | req_wen;
   assign rs       = ramstate_t'(ramstate);
   assign req_load = ramload;
   assign grant    = grant_q;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*32 +: 32];
      assign store_arr[gi] = req_store[gi*32 +: 32];
   end

   assign ramaddr  = addr_arr[grant_q];
   assign ramstore = store_arr[grant_q];

   rr_picker #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_picker (
      .req_i   (active),
      .ptr_i   (ptr_q),
      .valid_o (pick_valid),
      .index_o (pick_index)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= IW'(NREQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // ACCESS beats both a requester drop and timeout expiry in the same cycle.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      req_wait    = '1;
      timeout_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d = pick_index;
               cnt_d   = '0;
               state_d = XFER;
            end
         end
         XFER: begin
            ramWEN = req_wen[grant_q];
            ramREN = req_ren[grant_q] & ~req_wen[grant_q];
            if (rs == ACCESS) begin
               req_wait[grant_q] = 1'b0;
               ptr_d             = grant_q;
               state_d           = IDLE;
            end else if (!active[grant_q]) begin
               state_d = IDLE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               timeout_err = 1'b1;
               ptr_d       = grant_q;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
